// File: rtl/interrupt_controller.sv
// Fixed-priority interrupt controller: edge-detects peripheral events into sticky pending
// flags and hands one vector at a time to the CPU through an irq/ack/reti handshake.
module interrupt_controller #(
    parameter int NUM_IRQ      = 16,
    parameter int I_ADDR_WIDTH = 10,
    parameter int VECTOR_BASE  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IRQ-1:0]      irq_src,
    input  logic [NUM_IRQ-1:0]      irq_mask,
    input  logic                    global_ie,
    input  logic                    irq_ack,
    input  logic                    reti,
    input  logic                    clr_we,
    input  logic [NUM_IRQ-1:0]      clr_mask,
    output logic                    irq,
    output logic [I_ADDR_WIDTH-1:0] vector,
    output logic [NUM_IRQ-1:0]      pending,
    output logic                    in_service,
    output logic [1:0]              state_dbg
);

    localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t                  state_q;
    logic [NUM_IRQ-1:0]      src_q;
    logic [NUM_IRQ-1:0]      pending_q, pending_d;
    logic                    irq_q;
    logic [I_ADDR_WIDTH-1:0] vector_q;
    logic                    in_service_q;
    logic [IDX_W-1:0]        grant_q;

    logic [NUM_IRQ-1:0]      irq_event;
    logic [NUM_IRQ-1:0]      eligible;
    logic [IDX_W-1:0]        winner;
    logic                    ack_fire;

    assign irq_event = irq_src & ~src_q;
    assign eligible  = pending_q & irq_mask;
    assign ack_fire  = (state_q == REQUEST) && irq_ack;

    // Scan from the lowest priority upward so the lowest set index wins.
    always_comb begin
        winner = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) winner = IDX_W'(i);
        end
    end

    // A fresh event always beats a clear landing in the same cycle.
    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (irq_event[i])
                pending_d[i] = 1'b1;
            else if (ack_fire && (grant_q == IDX_W'(i)))
                pending_d[i] = 1'b0;
            else if (clr_we && clr_mask[i])
                pending_d[i] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            src_q        <= '0;
            pending_q    <= '0;
            irq_q        <= 1'b0;
            vector_q     <= '0;
            in_service_q <= 1'b0;
            grant_q      <= '0;
        end else begin
            src_q     <= irq_src;
            pending_q <= pending_d;
            case (state_q)
                IDLE: begin
                    if (global_ie && (eligible != '0)) begin
                        irq_q    <= 1'b1;
                        vector_q <= I_ADDR_WIDTH'(VECTOR_BASE) + I_ADDR_WIDTH'(winner);
                        grant_q  <= winner;
                        state_q  <= REQUEST;
                    end
                end
                REQUEST: begin
                    // Grant is frozen here; only ack or withdrawal leaves this state.
                    if (irq_ack) begin
                        irq_q        <= 1'b0;
                        in_service_q <= 1'b1;
                        state_q      <= SERVICE;
                    end else if (!global_ie || !eligible[grant_q]) begin
                        irq_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                SERVICE: begin
                    if (reti) begin
                        in_service_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    irq_q        <= 1'b0;
                    in_service_q <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign irq        = irq_q;
    assign vector     = vector_q;
    assign pending    = pending_q;
    assign in_service = in_service_q;
    assign state_dbg  = state_q;

endmodule
